bcd_sseg_scan: RTL and testbench
================================

Name: bcd_sseg_scan

Overview:
- Display-side consumer of the binary-to-BCD converter output. Captures four BCD digits when the converter signals completion.
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display, with optional leading-zero blanking and per-digit decimal point.
- Sits between the BCD converter and the board display pins. Shows the FIFO read value in decimal.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter. Top 2 bits select the digit (100 MHz gives ~381 Hz per digit). Minimum 3; use 4 in simulation.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- bcd_done  in  1  one-cycle pulse from the converter: bcd3..bcd0 are valid this cycle
- bcd3  in  4  thousands digit
- bcd2  in  4  hundreds digit
- bcd1  in  4  tens digit
- bcd0  in  4  units digit
- blank_lz  in  1  1 = blank leading zeros
- dp_in  in  4  decimal point per digit; bit i drives digit i; 0 = dp lit (active-low)
- sel  out  4  digit anode enables, active-low; sel[0] = rightmost (units)
- sseg  out  8  segments, active-low; bit7 = dp, bits6..0 = {g,f,e,d,c,b,a}
- digit_err  out  1  1 while any captured digit > 9

Behaviour:
- Reset (asynchronous, reset_n=0):
  - refresh counter = 0
  - captured digits = 0
  - sel = 4'b1111, sseg = 8'hFF, digit_err = 0
  - Reset mid-scan returns the outputs to these values immediately. After release, the scan restarts at digit 0.
- Capture:
  - On a rising clk with bcd_done=1, register bcd3..bcd0 into the capture bank.
  - Inputs are ignored when bcd_done=0.
  - Back-to-back pulses: the last one wins.
- Refresh counter:
  - Increments every clk and wraps from 2^REFRESH_BITS-1 to 0.
  - idx = counter[REFRESH_BITS-1:REFRESH_BITS-2]. idx 0→1→2→3→0 selects digit 0..3.
- Output pipeline:
  - sel and sseg are registered, one clk after idx and the capture bank.
  - sel drives exactly one bit low: bit idx. No all-off guard slot.
  - A capture and a digit change in the same cycle both take effect on the next registered output. The display never shows a mixed old/new digit within one slot.
- Decode, applied to the captured digit d[idx] and written to sseg[6:0]:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - 10..15 → dash 3F (segment g only)
- sseg[7] = dp_in[idx], sampled in the same cycle as idx.
- Leading-zero blanking:
  - Digit i (i = 1..3) is blanked when blank_lz=1 and every captured digit j ≥ i is 0.
  - Digit 0 is never blanked.
  - A blanked digit drives sseg[6:0]=7F. sseg[7] still follows dp_in, and sel is still asserted for that slot.
- digit_err is registered and updated on the cycle after each capture. It is 1 if any captured digit is > 9 and holds until the next capture or reset.
- blank_lz and dp_in are not captured. They are sampled live each cycle.

Test Plan:
- Reset release, REFRESH_BITS=4, no capture → sel cycles 1110,1101,1011,0111, each held 4 clks. sseg=C0 on every digit (dp_in=1111, blank_lz=0). digit_err=0.
- bcd_done pulse with 0,0,1,5 (bcd3..bcd0), blank_lz=1, dp_in=1111 → digit0 sseg=92, digit1 F9, digit2 FF, digit3 FF. With blank_lz=0, digits 2 and 3 show C0.
- Capture 9,8,7,6, dp_in=1011 → digit3 90, digit2 00 (dp lit), digit1 F8, digit0 82.
- Capture bcd1=12, others 0 → digit_err=1 one clk after the capture. Digit1 shows BF. Capturing 0,0,0,0 next clears digit_err on the following clk.
- bcd_done asserted on the same edge where idx changes to 0 (new bcd0=3, old 0) → the first registered digit-0 output is B0, never C0. Two consecutive bcd_done pulses (values 1 then 2 in bcd0) → 2 displayed.
- reset_n asserted asynchronously mid-slot on digit2 → sel=1111 and sseg=FF before the next clk edge. After release, the first lit slot is digit0 with sseg=C0.

Source files
------------

// File: rtl/bcd_sseg_scan.sv
// bcd_sseg_scan: captures four BCD digits from the converter and
// scans them onto a common-anode 4-digit seven-segment display.
module bcd_sseg_scan #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bcd_done,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       blank_lz,
    input  logic [3:0] dp_in,
    output logic [3:0] sel,
    output logic [7:0] sseg,
    output logic       digit_err
);

    localparam logic [REFRESH_BITS-1:0] CNT_ONE =
        {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] r_cnt;
    logic [3:0]              r_d0;
    logic [3:0]              r_d1;
    logic [3:0]              r_d2;
    logic [3:0]              r_d3;
    logic                    r_cap;
    logic [3:0]              r_sel;
    logic [7:0]              r_sseg;
    logic                    r_err;

    logic [1:0] w_idx;
    logic [3:0] w_digit;
    logic       w_z1;
    logic       w_z2;
    logic       w_z3;
    logic       w_blank;
    logic [6:0] w_seg;
    logic [3:0] w_sel;
    logic       w_bad;

    assign w_idx = r_cnt[REFRESH_BITS-1 -: 2];

    // Leading-zero chain: digit i is zero and so is everything left of it.
    assign w_z3 = (r_d3 == 4'd0);
    assign w_z2 = w_z3 && (r_d2 == 4'd0);
    assign w_z1 = w_z2 && (r_d1 == 4'd0);

    assign w_bad = (r_d0 > 4'd9) || (r_d1 > 4'd9) ||
                   (r_d2 > 4'd9) || (r_d3 > 4'd9);

    // Select the digit for the active slot and its blanking condition.
    always_comb begin
        w_digit = r_d0;
        w_blank = 1'b0;
        w_sel   = 4'b1110;
        unique case (w_idx)
            2'd0: begin
                w_digit = r_d0;
                w_blank = 1'b0;
                w_sel   = 4'b1110;
            end
            2'd1: begin
                w_digit = r_d1;
                w_blank = blank_lz && w_z1;
                w_sel   = 4'b1101;
            end
            2'd2: begin
                w_digit = r_d2;
                w_blank = blank_lz && w_z2;
                w_sel   = 4'b1011;
            end
            2'd3: begin
                w_digit = r_d3;
                w_blank = blank_lz && w_z3;
                w_sel   = 4'b0111;
            end
            default: begin
                w_digit = r_d0;
                w_blank = 1'b0;
                w_sel   = 4'b1110;
            end
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    always_comb begin
        w_seg = 7'h3F;
        if (w_blank) begin
            w_seg = 7'h7F;
        end else begin
            case (w_digit)
                4'd0:    w_seg = 7'h40;
                4'd1:    w_seg = 7'h79;
                4'd2:    w_seg = 7'h24;
                4'd3:    w_seg = 7'h30;
                4'd4:    w_seg = 7'h19;
                4'd5:    w_seg = 7'h12;
                4'd6:    w_seg = 7'h02;
                4'd7:    w_seg = 7'h78;
                4'd8:    w_seg = 7'h00;
                4'd9:    w_seg = 7'h10;
                default: w_seg = 7'h3F;
            endcase
        end
    end

    // Free-running refresh counter; its top two bits pick the slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Capture bank; the last pulse wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d0  <= 4'd0;
            r_d1  <= 4'd0;
            r_d2  <= 4'd0;
            r_d3  <= 4'd0;
            r_cap <= 1'b0;
        end else begin
            r_cap <= bcd_done;
            if (bcd_done) begin
                r_d0 <= bcd0;
                r_d1 <= bcd1;
                r_d2 <= bcd2;
                r_d3 <= bcd3;
            end
        end
    end

    // Registered display outputs, built from one coherent slot/bank view.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel  <= 4'b1111;
            r_sseg <= 8'hFF;
        end else begin
            r_sel  <= w_sel;
            r_sseg <= {dp_in[w_idx], w_seg};
        end
    end

    // Error flag re-evaluated only on the cycle after a capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_cap) begin
            r_err <= w_bad;
        end
    end

    assign sel       = r_sel;
    assign sseg      = r_sseg;
    assign digit_err = r_err;

endmodule

// File: tb/tb_bcd_sseg_scan.sv
// tb_bcd_sseg_scan: scoreboard bench for bcd_sseg_scan with a
// behavioural display model and randomized captures.
module tb_bcd_sseg_scan;

    localparam int RB   = 4;
    localparam int SLOT = 1 << (RB - 2);
    localparam int PER  = 1 << RB;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] sseg;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       bcd_done = 1'b0;
    logic [3:0] bcd3 = 4'd0;
    logic [3:0] bcd2 = 4'd0;
    logic [3:0] bcd1 = 4'd0;
    logic [3:0] bcd0 = 4'd0;
    logic       blank_lz = 1'b0;
    logic [3:0] dp_in = 4'hF;
    logic [3:0] sel;
    logic [7:0] sseg;
    logic       digit_err;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q[$];

    int         m_cycle;
    int         m_dig[4];
    bit         m_cap_prev;
    bit         m_err;
    logic [6:0] seg_tab[16];

    bcd_sseg_scan #(.REFRESH_BITS(RB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bcd_done (bcd_done),
        .bcd3     (bcd3),
        .bcd2     (bcd2),
        .bcd1     (bcd1),
        .bcd0     (bcd0),
        .blank_lz (blank_lz),
        .dp_in    (dp_in),
        .sel      (sel),
        .sseg     (sseg),
        .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_cycle    = 0;
        m_cap_prev = 0;
        m_err      = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endtask

    // Called at a negedge: drive inputs, predict the next edge's outputs.
    task automatic step(input bit done, input int d3, input int d2,
                        input int d1, input int d0,
                        input bit blz, input logic [3:0] dp);
        exp_t e;
        int   idx;
        bit   blank;
        bcd_done = done;
        bcd3 = 4'(d3);
        bcd2 = 4'(d2);
        bcd1 = 4'(d1);
        bcd0 = 4'(d0);
        blank_lz = blz;
        dp_in = dp;
        idx = (m_cycle / SLOT) % 4;
        blank = 0;
        if (blz && idx > 0) begin
            blank = 1;
            for (int j = idx; j < 4; j++)
                if (m_dig[j] != 0) blank = 0;
        end
        e.sel  = ~(4'b0001 << idx);
        e.sseg = {dp[idx], blank ? 7'h7F : seg_tab[m_dig[idx]]};
        if (m_cap_prev) begin
            m_err = 0;
            for (int j = 0; j < 4; j++)
                if (m_dig[j] > 9) m_err = 1;
        end
        e.err = m_err;
        q.push_back(e);
        if (done) begin
            m_dig[3] = d3;
            m_dig[2] = d2;
            m_dig[1] = d1;
            m_dig[0] = d0;
        end
        m_cap_prev = done;
        m_cycle = (m_cycle + 1) % PER;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit blz, input logic [3:0] dp);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, blz, dp);
    endtask

    // Monitor: compare every registered output against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sel", int'(sel), int'(e.sel));
                check("sseg", int'(sseg), int'(e.sseg));
                check("digit_err", int'(digit_err), int'(e.err));
            end
        end
    end

    initial begin
        int d[4];
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                    7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F,
                    7'h3F, 7'h3F};
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sel", int'(sel), 'hF);
        check("rst_sseg", int'(sseg), 'hFF);
        check("rst_err", int'(digit_err), 0);
        reset_n = 1'b1;

        idle(2 * PER, 0, 4'hF);

        step(1, 0, 0, 1, 5, 1, 4'hF);
        idle(PER, 1, 4'hF);
        idle(PER, 0, 4'hF);

        step(1, 9, 8, 7, 6, 0, 4'b1011);
        idle(PER, 0, 4'b1011);

        step(1, 0, 0, 12, 0, 0, 4'hF);
        idle(PER, 0, 4'hF);
        step(1, 0, 0, 0, 0, 0, 4'hF);
        idle(PER, 0, 4'hF);

        while (m_cycle != PER - 1) step(0, 0, 0, 0, 0, 0, 4'hF);
        step(1, 0, 0, 0, 3, 0, 4'hF);
        idle(PER, 0, 4'hF);
        step(1, 0, 0, 0, 1, 1, 4'hF);
        step(1, 0, 0, 0, 2, 1, 4'hF);
        idle(PER, 1, 4'hF);

        for (int i = 0; i < 2000; i++) begin
            for (int j = 0; j < 4; j++)
                d[j] = ($urandom_range(0, 7) == 0) ?
                       int'($urandom_range(0, 15)) :
                       (($urandom_range(0, 2) == 0) ? 0 :
                        int'($urandom_range(0, 9)));
            step($urandom_range(0, 9) == 0, d[3], d[2], d[1], d[0],
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        while (!(((m_cycle / SLOT) % 4 == 2) && (m_cycle % SLOT == 1)))
            step(0, 0, 0, 0, 0, 0, 4'hF);
        @(posedge clk);
        #2;
        check("pre_rst_sel", int'(sel), 'hB);
        reset_n = 1'b0;
        #1;
        check("async_sel", int'(sel), 'hF);
        check("async_sseg", int'(sseg), 'hFF);
        check("async_err", int'(digit_err), 0);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        idle(2 * PER, 0, 4'hF);

        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
